// File: rtl/clz_pkg.sv
// Shared constants, types and sizing helper for the pipelined count-leading-zeros engine.
package clz_pkg;

    localparam logic CLZ_MODE_LZ = 1'b0;
    localparam logic CLZ_MODE_TZ = 1'b1;

    // Position of the highest set bit inside one 4-bit group (0 = bit 3).
    typedef logic [1:0] clz_grp_t;

    function automatic int clz_grp_cnt(input int b_width);
        return 2 ** (b_width - 2);
    endfunction

endpackage

// File: rtl/clz_mod4_dec.sv
// Combinational 4-bit group decoder: leading-zero count within the nibble plus an empty flag.
module clz_mod4_dec
    import clz_pkg::*;
(
    input  logic [3:0] nib_i,
    output clz_grp_t   dec_o,
    output logic       emp_o
);

    always_comb begin
        dec_o = 2'd3;
        if (nib_i[3]) begin
            dec_o = 2'd0;
        end else if (nib_i[2]) begin
            dec_o = 2'd1;
        end else if (nib_i[1]) begin
            dec_o = 2'd2;
        end
    end

    assign emp_o = ~|nib_i;

endmodule

// File: rtl/clz_pipe.sv
// Two-stage streaming CLZ with valid/ready handshake and user sidecar.
// Define CLZ_PIPE_CTZ_EN to let s_mode=1 count trailing zeros instead.
module clz_pipe
    import clz_pkg::*;
#(
    parameter int B_WIDTH    = 6,
    parameter int USER_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [2**B_WIDTH-1:0]   s_data,
    input  logic                    s_mode,
    input  logic [USER_WIDTH-1:0]   s_user,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [B_WIDTH-1:0]      m_count,
    output logic                    m_zero,
    output logic [USER_WIDTH-1:0]   m_user
);

    localparam int W     = 2 ** B_WIDTH;
    localparam int G     = clz_grp_cnt(B_WIDTH);
    localparam int SEL_W = (B_WIDTH > 2) ? B_WIDTH - 2 : 1;

    logic en1, en2;
    logic v1_q, v2_q;

    assign en2     = ~v2_q | m_ready;
    assign en1     = ~v1_q | en2;
    assign s_ready = en1;

    logic [W-1:0] dec_in;

`ifdef CLZ_PIPE_CTZ_EN
    logic [W-1:0] data_rev;
    logic         s1_mode_q;
    logic         s1_mode_dbg_unused;

    for (genvar gi = 0; gi < W; gi++) begin : g_rev
        assign data_rev[gi] = s_data[W-1-gi];
    end

    // Trailing zeros of x are the leading zeros of bit-reversed x.
    assign dec_in = (s_mode == CLZ_MODE_TZ) ? data_rev : s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_mode_q <= CLZ_MODE_LZ;
        end else if (en1 && s_valid) begin
            s1_mode_q <= s_mode;
        end
    end

    assign s1_mode_dbg_unused = s1_mode_q;
`else
    logic mode_unused;

    assign dec_in      = s_data;
    assign mode_unused = s_mode;
`endif

    clz_grp_t grp_dec [G];
    logic [G-1:0] grp_emp;

    for (genvar gi = 0; gi < G; gi++) begin : g_grp
        clz_mod4_dec u_dec (
            .nib_i (dec_in[4*gi +: 4]),
            .dec_o (grp_dec[gi]),
            .emp_o (grp_emp[gi])
        );
    end

    clz_grp_t               s1_dec_q [G];
    logic [G-1:0]           s1_emp_q;
    logic [USER_WIDTH-1:0]  s1_user_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_emp_q  <= '0;
            s1_user_q <= '0;
            for (int g = 0; g < G; g++) begin
                s1_dec_q[g] <= '0;
            end
        end else if (en1) begin
            v1_q <= s_valid & s_ready;
            if (s_valid) begin
                s1_emp_q  <= grp_emp;
                s1_user_q <= s_user;
                for (int g = 0; g < G; g++) begin
                    s1_dec_q[g] <= grp_dec[g];
                end
            end
        end
    end

    // Highest non-empty group wins; an all-empty word falls back to group 0.
    logic [SEL_W-1:0]   sel;
    logic [B_WIDTH-1:0] count_d;
    logic               zero_d;

    always_comb begin
        sel = '0;
        for (int g = 0; g < G; g++) begin
            if (!s1_emp_q[g]) begin
                sel = SEL_W'(g);
            end
        end
    end

    if (B_WIDTH == 2) begin : g_single
        logic sel_unused;
        assign sel_unused = ^sel;
        assign count_d    = s1_dec_q[0];
    end else begin : g_multi
        assign count_d = {~sel, s1_dec_q[sel]};
    end

    assign zero_d = &s1_emp_q;

    logic [B_WIDTH-1:0]     count_q;
    logic                   zero_q;
    logic [USER_WIDTH-1:0]  user_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            count_q <= '0;
            zero_q  <= 1'b0;
            user_q  <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                count_q <= count_d;
                zero_q  <= zero_d;
                user_q  <= s1_user_q;
            end
        end
    end

    assign m_valid = v2_q;
    assign m_count = count_q;
    assign m_zero  = zero_q;
    assign m_user  = user_q;

endmodule

// File: tb/tb_clz_pipe.sv
// Self-checking bench for clz_pipe: directed vectors, stall/flush scenarios, random stream
// and exhaustive sweeps of the 4- and 8-bit builds against a bit-scan reference model.
module tb_clz_pipe;

`ifdef CLZ_PIPE_CTZ_EN
    localparam bit CTZ_EN = 1'b1;
`else
    localparam bit CTZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0;
    logic [63:0] s_data  = '0;
    logic        s_mode  = 1'b0;
    logic [7:0]  s_user  = '0;
    logic        m_ready = 1'b0;
    logic        s_ready, m_valid, m_zero;
    logic [5:0]  m_count;
    logic [7:0]  m_user;

    clz_pipe #(.B_WIDTH(6), .USER_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .m_zero(m_zero), .m_user(m_user)
    );

    logic       a_valid = 1'b0, a_mready = 1'b1, a_mode = 1'b0;
    logic [3:0] a_data = '0, a_user = '0, a_muser;
    logic       a_ready, a_mvalid, a_zero;
    logic [1:0] a_count;

    clz_pipe #(.B_WIDTH(2), .USER_WIDTH(4)) u_dut_b2 (
        .clk(clk), .rst(rst),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_mode(a_mode), .s_user(a_user),
        .m_valid(a_mvalid), .m_ready(a_mready), .m_count(a_count), .m_zero(a_zero), .m_user(a_muser)
    );

    logic       b_valid = 1'b0, b_mready = 1'b1, b_mode = 1'b0;
    logic [7:0] b_data = '0;
    logic [3:0] b_user = '0, b_muser;
    logic       b_ready, b_mvalid, b_zero;
    logic [2:0] b_count;

    clz_pipe #(.B_WIDTH(3), .USER_WIDTH(4)) u_dut_b3 (
        .clk(clk), .rst(rst),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_mode(b_mode), .s_user(b_user),
        .m_valid(b_mvalid), .m_ready(b_mready), .m_count(b_count), .m_zero(b_zero), .m_user(b_muser)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] cnt;
        logic       zero;
        logic [7:0] user;
    } exp_t;

    typedef struct {
        logic [63:0] d;
        logic        mode;
        logic [7:0]  user;
        logic [5:0]  cnt;
        logic        zero;
    } vec_t;

    // Reference: scan bits from the relevant end; all-zero word reports w-1.
    function automatic int ref_count(input logic [63:0] d, input int w, input bit tz);
        if (tz) begin
            for (int i = 0; i < w; i++) begin
                if (d[i]) return i;
            end
        end else begin
            for (int i = w - 1; i >= 0; i--) begin
                if (d[i]) return w - 1 - i;
            end
        end
        return w - 1;
    endfunction

    function automatic exp_t model64(input logic [63:0] d, input logic mode, input logic [7:0] user);
        exp_t e;
        e.cnt  = 6'(ref_count(d, 64, CTZ_EN && mode));
        e.zero = (d == 64'd0);
        e.user = user;
        return e;
    endfunction

    task automatic test_reset;
        checks++;
        if (m_valid !== 1'b0 || m_count !== 6'd0 || m_zero !== 1'b0 || m_user !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cnt=%0d z=%b u=%h expected v=0 cnt=0 z=0 u=00",
                     m_valid, m_count, m_zero, m_user);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %b expected 1", s_ready);
        end
        checks++;
        if (a_mvalid !== 1'b0 || b_mvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_small_valid: got %b/%b expected 0/0", a_mvalid, b_mvalid);
        end
    endtask

    // Single beats with an empty pipe: exact 2-cycle latency and known counts.
    task automatic test_directed;
        vec_t vecs[$];
        vecs.push_back('{64'h0000_0000_0001_0000, 1'b0, 8'hA5, 6'd47, 1'b0});
        vecs.push_back('{64'h0, 1'b0, 8'h3C, 6'd63, 1'b1});
        vecs.push_back('{64'hF000_0000_0000_0000, 1'b0, 8'h01, 6'd0, 1'b0});
        vecs.push_back('{64'h0000_0000_0000_0008, 1'b0, 8'h02, 6'd60, 1'b0});
        if (CTZ_EN) begin
            vecs.push_back('{64'h100, 1'b1, 8'h77, 6'd8, 1'b0});
            vecs.push_back('{64'h0, 1'b1, 8'h78, 6'd63, 1'b1});
        end else begin
            vecs.push_back('{64'h100, 1'b1, 8'h77, 6'd55, 1'b0});
            vecs.push_back('{64'h0, 1'b1, 8'h78, 6'd63, 1'b1});
        end
        foreach (vecs[k]) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = vecs[k].d; s_mode = vecs[k].mode; s_user = vecs[k].user;
            m_ready = 1'b1;
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_ready[%0d]: got %b expected 1", k, s_ready);
            end
            @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_early[%0d]: m_valid got %b expected 0 one cycle after accept", k, m_valid);
            end
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_count !== vecs[k].cnt || m_zero !== vecs[k].zero || m_user !== vecs[k].user) begin
                errors++;
                $display("FAIL directed[%0d] d=%h mode=%b: got v=%b cnt=%0d z=%b u=%h expected v=1 cnt=%0d z=%b u=%h",
                         k, vecs[k].d, vecs[k].mode, m_valid, m_count, m_zero, m_user,
                         vecs[k].cnt, vecs[k].zero, vecs[k].user);
            end
            $display("directed d=%h mode=%b -> cnt=%0d zero=%b user=%h", vecs[k].d, vecs[k].mode, m_count, m_zero, m_user);
        end
        s_mode = 1'b0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 64'h8000_0000_0000_0000; s_user = 8'h10;
        @(negedge clk);
        s_data = 64'h1; s_user = 8'h11;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_count !== 6'd0 || m_zero !== 1'b0 || m_user !== 8'h10) begin
            errors++;
            $display("FAIL b2b_first: got v=%b cnt=%0d z=%b u=%h expected v=1 cnt=0 z=0 u=10", m_valid, m_count, m_zero, m_user);
        end
        $display("b2b beat0 cnt=%0d zero=%b", m_count, m_zero);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_count !== 6'd63 || m_zero !== 1'b0 || m_user !== 8'h11) begin
            errors++;
            $display("FAIL b2b_second: got v=%b cnt=%0d z=%b u=%h expected v=1 cnt=63 z=0 u=11", m_valid, m_count, m_zero, m_user);
        end
        $display("b2b beat1 cnt=%0d zero=%b", m_count, m_zero);
        @(negedge clk);
    endtask

    // Continuous source of 20 beats while the sink stalls for cycles 5..9.
    task automatic test_stall;
        exp_t q[$];
        exp_t e;
        int   sent = 0, got = 0;
        bit   saw_block = 1'b0, held = 1'b0;
        logic [5:0] h_cnt; logic h_zero; logic [7:0] h_user;
        for (int c = 0; c < 100 && got < 20; c++) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if (m_valid !== 1'b1 || m_count !== h_cnt || m_zero !== h_zero || m_user !== h_user) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d: got v=%b cnt=%0d u=%h expected v=1 cnt=%0d u=%h",
                             c, m_valid, m_count, m_user, h_cnt, h_user);
                end
            end
            s_valid = (sent < 20);
            s_data  = 64'(sent + 1);
            s_user  = 8'(sent);
            m_ready = !(c >= 5 && c <= 9);
            #1;
            if (s_valid && !s_ready) saw_block = 1'b1;
            if (m_valid && m_ready) begin
                e = q.pop_front();
                got++;
                checks++;
                if (m_count !== e.cnt || m_zero !== e.zero || m_user !== e.user) begin
                    errors++;
                    $display("FAIL stall_beat: got cnt=%0d z=%b u=%h expected cnt=%0d z=%b u=%h",
                             m_count, m_zero, m_user, e.cnt, e.zero, e.user);
                end
                $display("stall beat user=%h cnt=%0d", m_user, m_count);
            end
            held = m_valid && !m_ready;
            h_cnt = m_count; h_zero = m_zero; h_user = m_user;
            if (s_valid && s_ready) begin
                q.push_back(model64(s_data, 1'b0, s_user));
                sent++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (got != 20 || sent != 20) begin
            errors++;
            $display("FAIL stall_count: got %0d delivered %0d sent expected 20/20", got, sent);
        end
        checks++;
        if (!saw_block) begin
            errors++;
            $display("FAIL stall_backpressure: s_ready never dropped, expected it low while both stages full");
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_extra: m_valid got %b expected 0 after last beat", m_valid);
        end
    endtask

    task automatic test_reset_flush;
        int seen = 0;
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 64'h1234; s_user = 8'hE1;
        @(negedge clk);
        s_data = 64'h5678; s_user = 8'hE2;
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_count !== 6'd0 || m_user !== 8'd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: got v=%b cnt=%0d u=%h rdy=%b expected v=0 cnt=0 u=00 rdy=1",
                     m_valid, m_count, m_user, s_ready);
        end
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_stale: got %0d stale beats expected 0", seen);
        end
        @(negedge clk);
        s_valid = 1'b1; s_data = 64'h0F00; s_user = 8'h5A;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_early: m_valid got %b expected 0", m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_count !== 6'd52 || m_user !== 8'h5A) begin
            errors++;
            $display("FAIL flush_next: got v=%b cnt=%0d u=%h expected v=1 cnt=52 u=5A", m_valid, m_count, m_user);
        end
        $display("flush next beat cnt=%0d user=%h", m_count, m_user);
        @(negedge clk);
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        bit   held = 1'b0;
        logic [5:0] h_cnt; logic [7:0] h_user;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if (m_valid !== 1'b1 || m_count !== h_cnt || m_user !== h_user) begin
                    errors++;
                    $display("FAIL random_hold c=%0d: got v=%b cnt=%0d u=%h expected v=1 cnt=%0d u=%h",
                             c, m_valid, m_count, m_user, h_cnt, h_user);
                end
            end
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = {$urandom, $urandom} >> $urandom_range(0, 64);
            s_mode  = $urandom_range(0, 1);
            s_user  = 8'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (m_valid && m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL random_spurious: got beat u=%h expected none", m_user);
                end else begin
                    e = q.pop_front();
                    if (m_count !== e.cnt || m_zero !== e.zero || m_user !== e.user) begin
                        errors++;
                        $display("FAIL random_beat: got cnt=%0d z=%b u=%h expected cnt=%0d z=%b u=%h",
                                 m_count, m_zero, m_user, e.cnt, e.zero, e.user);
                    end
                end
                $display("random beat user=%h cnt=%0d zero=%b", m_user, m_count, m_zero);
            end
            held = m_valid && !m_ready;
            h_cnt = m_count; h_user = m_user;
            if (s_valid && s_ready) q.push_back(model64(s_data, s_mode, s_user));
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (m_valid) begin
                e = q.pop_front();
                checks++;
                if (m_count !== e.cnt || m_zero !== e.zero || m_user !== e.user) begin
                    errors++;
                    $display("FAIL random_drain: got cnt=%0d u=%h expected cnt=%0d u=%h", m_count, m_user, e.cnt, e.user);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL random_lost: got %0d beats undelivered expected 0", q.size());
        end
        s_mode = 1'b0;
    endtask

    // Exhaustive sweep of the 4-bit and 8-bit builds, sink always ready.
    task automatic test_small_widths;
        int qa_c[$], qb_c[$];
        int qa_u[$], qb_u[$];
        int got_a = 0, got_b = 0, ec, eu;
        for (int i = 0; i < 262; i++) begin
            @(negedge clk);
            if (a_mvalid) begin
                ec = qa_c.pop_front(); eu = qa_u.pop_front();
                got_a++;
                checks++;
                if (a_count !== 2'(ec) || a_zero !== (eu == 0) || a_muser !== 4'(eu)) begin
                    errors++;
                    $display("FAIL b2_sweep d=%h: got cnt=%0d z=%b u=%h expected cnt=%0d z=%b",
                             eu, a_count, a_zero, a_muser, ec, (eu == 0));
                end
                $display("b2 beat d=%h cnt=%0d zero=%b", a_muser, a_count, a_zero);
            end
            if (b_mvalid) begin
                ec = qb_c.pop_front(); eu = qb_u.pop_front();
                got_b++;
                checks++;
                if (b_count !== 3'(ec) || b_zero !== (eu == 0) || b_muser !== 4'(eu)) begin
                    errors++;
                    $display("FAIL b3_sweep d=%h: got cnt=%0d z=%b u=%h expected cnt=%0d z=%b",
                             eu, b_count, b_zero, b_muser, ec, (eu == 0));
                end
                $display("b3 beat d=%h cnt=%0d zero=%b", eu, b_count, b_zero);
            end
            a_valid = (i < 16);
            a_data  = 4'(i);
            a_user  = 4'(i);
            b_valid = (i < 256);
            b_data  = 8'(i);
            b_user  = 4'(i);
            #1;
            if (a_valid && a_ready) begin
                qa_c.push_back(ref_count(64'(a_data), 4, 1'b0));
                qa_u.push_back(i);
            end
            if (b_valid && b_ready) begin
                qb_c.push_back(ref_count(64'(b_data), 8, 1'b0));
                qb_u.push_back(i);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if (got_a != 16 || got_b != 256) begin
            errors++;
            $display("FAIL small_sweep_count: got %0d/%0d beats expected 16/256", got_a, got_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_random();
        test_small_widths();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clz_pipe.md
Name: clz_pipe

Overview:
Pipelined, streaming count-leading-zeros engine for the PCIe datapath. It is generalised to data widths of 4 to 64 bits.
- Uses the same modulus-4 group decode as the combinational CLZ: per-nibble position plus nibble-empty flags, then a priority select over the groups.
- Splits that decode across two register stages behind a valid/ready handshake.
- Carries a user sidecar through the pipeline.
- Can optionally count trailing zeros instead of leading zeros.
- Used for DMA descriptor free-slot search and for TLP byte-enable alignment at 250 MHz, where the single-cycle 64-bit CLZ does not close timing.

Parameters:
B_WIDTH, 6, log2 of data width; legal 2..6, so data width is 2**B_WIDTH bits.
USER_WIDTH, 8, width of the opaque sidecar passed alongside each beat; legal 1..32.

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
s_data  in  2**B_WIDTH  operand
s_mode  in  1  0 = CLZ, 1 = CTZ (CTZ only with CLZ_PIPE_CTZ_EN)
s_user  in  USER_WIDTH  sidecar
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid & m_ready
m_count  out  B_WIDTH  zero count
m_zero  out  1  operand was all-zero; m_count is then all-ones
m_user  out  USER_WIDTH  sidecar of the same beat

Behaviour:
- Reset values (synchronous, rst high at a clk edge):
  - m_valid=0, m_count=0, m_zero=0, m_user=0.
  - Internal stage valids are 0 and stage data is 0.
  - Beats in flight are discarded. s_ready=1 in the cycle after reset deasserts.
- Stage 1 (register S1), loaded on the accept:
  - Operand is bit-reversed first if the mode is CTZ.
  - Per group g of 4 bits (2**(B_WIDTH-2) groups), S1 stores:
    - dec[g] = 0/1/2/3 for the highest set bit at position 3/2/1/0 of the group, else 3;
    - emp[g] = group is all-zero.
  - S1 also stores user and mode.
- Stage 2 (register S2 = outputs):
  - sel = index of the highest group with emp=0 (0 if none).
  - m_count = { ~sel , dec[sel] }, width B_WIDTH.
  - m_zero = AND of all emp.
  - B_WIDTH=2: a single group; m_count = dec[0].
- Latency: exactly 2 cycles from the accept edge to m_valid, with no stalls.
- Throughput: 1 beat per cycle while m_ready=1.
- Flow control:
  - en2 = ~v2 | m_ready
  - en1 = ~v1 | en2
  - s_ready = en1 (combinational from m_ready, no skid)
- Stage valid updates:
  - v1 loads s_valid&s_ready when en1.
  - v2 loads v1 when en2.
  - Data registers load only when their enable is high.
- Stall: m_valid, m_count, m_zero and m_user hold stable while m_valid & ~m_ready. No beat is dropped or duplicated and order is preserved.
- Simultaneous accept and emit when full: both stages advance in the same cycle and s_ready stays 1.
- All-zero operand: m_count = 2**B_WIDTH-1, m_zero=1, in both CLZ and CTZ modes.
- Widths: count is unsigned B_WIDTH bits with no wrap; the maximum meaningful count is 2**B_WIDTH-1.

Optional Feature:
CLZ_PIPE_CTZ_EN
- Defined: s_mode=1 bit-reverses s_data before the S1 decode, so m_count gives the number of trailing zeros. The mode bit is registered in S1 for debug.
- Undefined: s_mode is ignored, there is no reversal logic and no mode register, and every beat is CLZ.
- Latency and handshake are identical in both builds.

Decomposition:
- Package clz_pkg holds:
  - localparams CLZ_MODE_LZ=1'b0 and CLZ_MODE_TZ=1'b1;
  - function clz_grp_cnt(B_WIDTH) = 2**(B_WIDTH-2);
  - typedef clz_grp_t for the 2-bit group decode.
- One sub-module, clz_mod4_dec: a combinational 4-bit group decoder producing dec[1:0] and emp. It is instanced per group in a generate loop feeding S1.
- Priority select and output registers stay in clz_pipe.

Test Plan:
1. B_WIDTH=6, CLZ, s_data=64'h0000_0000_0001_0000, user=8'hA5 -> 2 cycles later m_count=47, m_zero=0, m_user=8'hA5.
2. s_data=64'h8000_0000_0000_0000 then 64'h1 back-to-back -> m_count=0 then 63 on consecutive cycles, both with m_zero=0.
3. s_data=0 -> m_count=63, m_zero=1. With CLZ_PIPE_CTZ_EN, CTZ of 64'h100 -> m_count=8 and CTZ of 64'h0 -> m_count=63, m_zero=1.
4. s_valid held high with 20 incrementing operands, m_ready low for cycles 5-9:
   - s_ready falls once both stages are full;
   - outputs hold stable during the stall;
   - all 20 results arrive in order with no loss or duplication.
5. rst asserted for 1 cycle with 2 beats in flight -> m_valid=0 next cycle, no stale beat emitted, and the next accepted beat appears 2 cycles later.
6. B_WIDTH=2 and B_WIDTH=3 builds: exhaustively sweep all 16 and 256 operands -> m_count and m_zero match a reference CLZ model.
